// File: rtl/montgomery_form_converter.sv
// Converts a plain operand x into Montgomery form x*2^k mod M using a bit-serial
// reduce-then-scale shift/subtract datapath.
module montgomery_form_converter #(
  parameter int unsigned DATA_LENGTH = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [DATA_LENGTH-1:0] x_i,
  input  logic [DATA_LENGTH-1:0] m_i,
  input  logic [DATA_LENGTH-1:0] m_bl_i,
  output logic                   busy_o,
  output logic [DATA_LENGTH-1:0] result_o,
  output logic                   valid_o,
  output logic                   error_o
);

  localparam int unsigned ACC_W = DATA_LENGTH + 1;
  localparam int unsigned CNT_W = $clog2(DATA_LENGTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_REDUCE, S_SCALE, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [DATA_LENGTH-1:0] x_q, x_d;
  logic [ACC_W-1:0]       m_q, m_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]       k_q, k_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [DATA_LENGTH-1:0] result_q, result_d;
  logic                   error_q, error_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;

  logic                   operands_ok_c;
  logic                   shift_in_c;
  logic [ACC_W-1:0]       acc_shift_c;
  logic [ACC_W-1:0]       acc_red_c;

  // Odd modulus >= 3 whose bit length k lies in 1..DATA_LENGTH and covers M.
  assign operands_ok_c = (m_i >= DATA_LENGTH'(3)) && m_i[0] &&
                         (m_bl_i != '0) && (m_bl_i <= DATA_LENGTH'(DATA_LENGTH)) &&
                         ((m_i >> m_bl_i) == '0);

  // One doubling step; acc < M before the step keeps a single subtraction sufficient.
  assign shift_in_c  = (state_q == S_REDUCE) ? x_q[DATA_LENGTH-1] : 1'b0;
  assign acc_shift_c = (acc_q << 1) | ACC_W'(shift_in_c);
  assign acc_red_c   = (acc_shift_c >= m_q) ? (acc_shift_c - m_q) : acc_shift_c;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      m_q      <= '0;
      acc_q    <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
      error_q  <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      result_q <= result_d;
      error_q  <= error_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    m_d      = m_q;
    acc_d    = acc_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    result_d = result_q;
    error_d  = error_q;
    valid_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          x_d   = x_i;
          m_d   = {1'b0, m_i};
          k_d   = CNT_W'(m_bl_i);
          acc_d = '0;
          cnt_d = '0;
          err_d = !operands_ok_c;
          state_d = operands_ok_c ? S_REDUCE : S_DONE;
        end
      end
      S_REDUCE: begin
        acc_d = acc_red_c;
        x_d   = {x_q[DATA_LENGTH-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_LENGTH - 1)) begin
          cnt_d   = '0;
          state_d = S_SCALE;
        end
      end
      S_SCALE: begin
        acc_d = acc_red_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == (k_q - CNT_W'(1))) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        valid_d  = 1'b1;
        result_d = err_q ? '0 : acc_q[DATA_LENGTH-1:0];
        error_d  = err_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign busy_o   = busy_q;
  assign result_o = result_q;
  assign valid_o  = valid_q;
  assign error_o  = error_q;

endmodule

// File: tb/tb_montgomery_form_converter.sv
// Directed and table-driven checks of montgomery_form_converter at DATA_LENGTH=32.
module tb_montgomery_form_converter;

  localparam int unsigned DL = 32;
  localparam logic [31:0] MQ = 32'd8380417;
  localparam logic [31:0] KQ = 32'd23;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] x, m, mbl;
  logic [31:0] result;
  logic        busy, valid, error;

  int n_cmp = 0;
  int n_bad = 0;

  montgomery_form_converter #(.DATA_LENGTH(DL)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .x_i(x), .m_i(m), .m_bl_i(mbl),
    .busy_o(busy), .result_o(result), .valid_o(valid), .error_o(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] m;
    logic [31:0] k;
    logic [31:0] res;
    logic        err;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Independent arithmetic model: (x mod M) * 2^k mod M on wide integers.
  function automatic logic [31:0] model(input logic [31:0] xv, input logic [31:0] mv,
                                        input logic [31:0] kv);
    logic [127:0] p;
    p = 128'(xv % mv) << kv;
    return 32'(p % 128'(mv));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One conversion; inputs are scrambled right after the start edge.
  task automatic run(input logic [31:0] xv, input logic [31:0] mv, input logic [31:0] kv,
                     output logic [31:0] res, output logic err, output int lat,
                     output logic busy_ok);
    x = xv; m = mv; mbl = kv; start = 1'b1;
    step();
    start = 1'b0; x = ~xv; m = 32'd4; mbl = 32'd0;
    lat = 0;
    busy_ok = busy;
    while (lat < 300) begin
      step();
      lat++;
      if (valid) break;
      if (!busy) busy_ok = 1'b0;
    end
    res = result;
    err = error;
  endtask

  initial begin
    logic [31:0] res;
    logic        err, bok;
    int          lat, e1, e2, nv;

    vecs[0]  = '{32'd1,        MQ,            KQ,    32'h00001FFF, 1'b0};
    vecs[1]  = '{32'd0,        MQ,            KQ,    32'h0,        1'b0};
    vecs[2]  = '{32'd8380417,  MQ,            KQ,    32'h0,        1'b0};
    vecs[3]  = '{32'd8380418,  MQ,            KQ,    32'h00001FFF, 1'b0};
    vecs[4]  = '{32'd2,        MQ,            KQ,    32'h00003FFE, 1'b0};
    vecs[5]  = '{32'hFFFFFFFF, MQ,            KQ,    model(32'hFFFFFFFF, MQ, KQ), 1'b0};
    vecs[6]  = '{32'd5,        32'd13,        32'd4, 32'd2,        1'b0};
    vecs[7]  = '{32'hFFFFFFFF, 32'd13,        32'd4, 32'd11,       1'b0};
    vecs[8]  = '{32'd7,        32'd3,         32'd2, 32'd1,        1'b0};
    vecs[9]  = '{32'd1,        32'hFFFFFFFB,  32'd32, 32'd5,       1'b0};
    vecs[10] = '{32'd1,        32'd8380416,   KQ,    32'h0,        1'b1};
    vecs[11] = '{32'd1,        MQ,            32'd0, 32'h0,        1'b1};
    vecs[12] = '{32'd1,        32'd1,         32'd1, 32'h0,        1'b1};
    vecs[13] = '{32'd1,        32'd13,        32'd33, 32'h0,       1'b1};
    vecs[14] = '{32'd1,        MQ,            32'd22, 32'h0,       1'b1};

    rst = 1'b1; start = 1'b0; x = '0; m = '0; mbl = '0;
    step(); step();
    rst = 1'b0;
    check("reset_result", 64'(result), 64'd0);
    check("reset_valid",  64'(valid),  64'd0);
    check("reset_busy",   64'(busy),   64'd0);
    check("reset_error",  64'(error),  64'd0);

    foreach (vecs[i]) begin
      run(vecs[i].x, vecs[i].m, vecs[i].k, res, err, lat, bok);
      check($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].res));
      check($sformatf("vec%0d_error", i),  64'(err), 64'(vecs[i].err));
      check($sformatf("vec%0d_latency", i), 64'(lat),
            vecs[i].err ? 64'd1 : 64'(DL + vecs[i].k + 1));
      check($sformatf("vec%0d_busy", i), 64'(bok), 64'd1);
      step();
      check($sformatf("vec%0d_pulse", i), 64'(valid), 64'd0);
    end

    // Outputs hold after completion while inputs wander.
    run(32'd5, 32'd13, 32'd4, res, err, lat, bok);
    x = 32'd9; m = 32'd99; mbl = 32'd7;
    repeat (5) step();
    check("hold_result", 64'(result), 64'd2);
    check("hold_busy", 64'(busy), 64'd0);
    run(32'd5, 32'd8380416, KQ, res, err, lat, bok);
    repeat (5) step();
    check("hold_error", 64'(error), 64'd1);

    // Start re-asserted mid-REDUCE is ignored.
    x = 32'd1; m = MQ; mbl = KQ; start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    x = 32'd2; start = 1'b1;
    bok = 1'b1;
    repeat (15) begin step(); if (!busy) bok = 1'b0; end
    start = 1'b0;
    nv = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (valid) begin nv++; res = result; end
      if (nv == 0 && !busy) bok = 1'b0;
    end
    check("ignore_count", 64'(nv), 64'd1);
    check("ignore_result", 64'(res), 64'h1FFF);
    check("ignore_busy", 64'(bok), 64'd1);

    // Start held high: back-to-back conversions.
    x = 32'd1; m = MQ; mbl = KQ; start = 1'b1;
    step();
    e1 = 0; e2 = 0; lat = 0;
    while (lat < 300 && e2 == 0) begin
      step();
      lat++;
      if (valid) begin
        if (e1 == 0) e1 = lat;
        else begin e2 = lat; start = 1'b0; end
      end
    end
    start = 1'b0;
    check("b2b_first", 64'(e1), 64'd56);
    check("b2b_gap", 64'(e2 - e1), 64'd57);
    repeat (3) step();

    // Reset at cycle 10 aborts the conversion.
    x = 32'd1; m = MQ; mbl = KQ; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_result", 64'(result), 64'd0);
    check("abort_valid",  64'(valid),  64'd0);
    check("abort_busy",   64'(busy),   64'd0);
    check("abort_error",  64'(error),  64'd0);
    nv = 0;
    repeat (80) begin step(); if (valid) nv++; end
    check("abort_novalid", 64'(nv), 64'd0);
    run(32'd2, MQ, KQ, res, err, lat, bok);
    check("after_reset_result", 64'(res), 64'h3FFE);
    check("after_reset_latency", 64'(lat), 64'd56);

    // Reset wins over a simultaneous start.
    x = 32'd1; m = MQ; mbl = KQ; start = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    check("rst_prio_busy", 64'(busy), 64'd0);
    nv = 0;
    repeat (70) begin step(); if (valid) nv++; end
    check("rst_prio_novalid", 64'(nv), 64'd0);

    // Random regression against the arithmetic model.
    for (int r = 0; r < 1000; r++) begin
      logic [31:0] xr;
      xr = $urandom;
      run(xr, MQ, KQ, res, err, lat, bok);
      check($sformatf("rand%0d_result", r), 64'(res), 64'(model(xr, MQ, KQ)));
      check($sformatf("rand%0d_error", r), 64'(err), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/montgomery_form_converter.md
MONTGOMERY_FORM_CONVERTER -- requirements
Module: montgomery_form_converter

Interface
REQ-001 SHALL have parameter DATA_LENGTH, default 64, width of operand and result words.
REQ-002 SHALL have one clock and a synchronous, active-high reset; ports named as below.
REQ-003 SHALL have port clk_i  input  1  rising-edge clock.
REQ-004 SHALL have port rst_i  input  1  synchronous active-high reset.
REQ-005 SHALL have port start_i  input  1  start request, sampled in IDLE only.
REQ-006 SHALL have port x_i  input  DATA_LENGTH  plain-domain operand, any value.
REQ-007 SHALL have port m_i  input  DATA_LENGTH  modulus M.
REQ-008 SHALL have port m_bl_i  input  DATA_LENGTH  modulus bit length k; R = 2^k.
REQ-009 SHALL have port busy_o  output  1  high while a conversion is in progress.
REQ-010 SHALL have port result_o  output  DATA_LENGTH  Montgomery-form result x*R mod M.
REQ-011 SHALL have port valid_o  output  1  one-cycle completion pulse.
REQ-012 SHALL have port error_o  output  1  invalid-operand flag, qualified by valid_o.

Function
REQ-013 SHALL compute result_o = (x_i * 2^k) mod M, feeding the digit-parallel Montgomery multiplier's x input.
REQ-014 SHALL latch x_i, m_i, m_bl_i on the edge where start_i=1 in IDLE; later input changes have no effect.
REQ-015 SHALL implement states IDLE, REDUCE, SCALE, DONE.
REQ-016 IDLE: start_i=1 with valid operands -> REDUCE; with invalid operands -> DONE with error.
REQ-017 Operands are invalid if m_i < 3, m_i even, m_bl_i = 0, m_bl_i > DATA_LENGTH, or m_i >= 2^m_bl_i.
REQ-018 REDUCE: DATA_LENGTH cycles, x processed MSB first; acc <= 2*acc + bit; if acc >= M then acc <= acc - M.
REQ-019 SCALE: k cycles; acc <= 2*acc; if acc >= M then acc <= acc - M.
REQ-020 Accumulator SHALL be DATA_LENGTH+1 bits wide so doubling never overflows; acc < M holds after every step.
REQ-021 DONE: one cycle; valid_o=1, result_o=acc (0 on error), error_o set per REQ-017; then -> IDLE.
REQ-022 Valid-operand latency: valid_o high in the cycle following the (DATA_LENGTH + k + 1)-th rising edge after the edge sampling start_i.
REQ-023 Invalid-operand latency: valid_o high in the cycle following the first edge after the start edge.
REQ-024 busy_o SHALL be high in REDUCE, SCALE and DONE, low in IDLE.
REQ-025 start_i while busy_o=1 SHALL be ignored, with no queuing.
REQ-026 result_o and error_o SHALL hold their values after DONE until the next accepted start.
REQ-027 start_i held high continuously SHALL start a new conversion on the first IDLE cycle after DONE.

Reset
REQ-028 rst_i=1 at a rising edge SHALL force IDLE, acc=0, result_o=0, valid_o=0, busy_o=0, error_o=0.
REQ-029 Reset mid-operation SHALL abort the conversion with no valid_o pulse; a start after reset release behaves normally.
REQ-030 Reset SHALL take priority over start_i at the same edge.

Verification (DATA_LENGTH=32, M=8380417, k=23 unless stated)
REQ-031 x=1 -> result_o=0x00001FFF, error_o=0, valid_o exactly 56 edges after start, single-cycle pulse.
REQ-032 x=0, then x=8380417, then x=8380418 -> results 0, 0, 0x00001FFF; x=0xFFFFFFFF -> result matches a (x*2^23) mod M software model.
REQ-033 m_i=8380416 (even) -> valid_o after 1 edge, error_o=1, result_o=0; m_bl_i=0 -> same response.
REQ-034 Pulse start_i with x=1, then assert start_i with x=2 mid-REDUCE -> only one valid_o, result 0x00001FFF; busy_o stays high throughout.
REQ-035 Assert rst_i at cycle 10 of a conversion -> no valid_o, all outputs 0 next cycle; then x=2 -> result 0x00003FFE.
REQ-036 Random regression of 1000 operands against the model -> all results match, error_o=0.
